// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam int   I2C_FILT_LEN = 3;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// I2C pin bundle: raw line levels in, open-drain pull-down enables out.
interface i2c_target_regfile_if;
  logic i2c_sda_in;
  logic i2c_scl_in;
  logic i2c_sda_oe;
  logic i2c_scl_oe;

  modport master (output i2c_sda_in, i2c_scl_in, input  i2c_sda_oe, i2c_scl_oe);
  modport slave  (input  i2c_sda_in, i2c_scl_in, output i2c_sda_oe, i2c_scl_oe);
endinterface

// File: rtl/i2c_line_cond.sv
// One I2C line: 2-flop synchronizer, optional 3-sample stability filter
// (I2C_TARGET_GLITCH_FILTER_EN), and rise/fall detection on the result.
module i2c_line_cond
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       lvl_q;

  // Idle bus level is high, so everything resets to 1.
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], pin};

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [I2C_FILT_LEN-2:0] hist;
  logic [I2C_FILT_LEN-1:0] win;
  logic                    filt;

  assign win = {hist, sync[1]};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= '1;
      filt <= 1'b1;
    end else begin
      hist <= win[I2C_FILT_LEN-2:0];
      if (&win)       filt <= 1'b1;
      else if (~|win) filt <= 1'b0;
    end

  assign level = filt;
`else
  assign level = sync[1];
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) lvl_q <= 1'b1;
    else     lvl_q <= level;

  assign rise = level & ~lvl_q;
  assign fall = ~level & lvl_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing NUM_REGS byte registers; pointer-then-data writes,
// auto-incrementing reads. Optional input glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDR     = 7'h42,
  parameter int         NUM_REGS = 16,
  parameter int         PW       = $clog2(NUM_REGS)
) (
  input  logic                    clk_in_clk,
  input  logic                    reset_reset,
  i2c_target_regfile_if.slave     i2c,
  input  logic                    loc_we,
  input  logic [PW-1:0]           loc_addr,
  input  logic [7:0]              loc_wdata,
  output logic [8*NUM_REGS-1:0]   regs_out,
  output logic                    wr_pulse,
  output logic [PW-1:0]           wr_addr,
  output logic                    bus_active
);

  localparam int SCL = 0;
  localparam int SDA = 1;

  logic [1:0] pins, lvl, rise, fall;

  assign pins = {i2c.i2c_sda_in, i2c.i2c_scl_in};

  i2c_line_cond u_line [1:0] (
    .clk   (clk_in_clk),
    .rst   (reset_reset),
    .pin   (pins),
    .level (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  logic start_det, stop_det;
  assign start_det = lvl[SCL] & fall[SDA];
  assign stop_det  = lvl[SCL] & rise[SDA];

  i2c_tgt_state_t               state, state_n;
  logic [2:0]                   bit_cnt, bit_cnt_n;
  logic [7:0]                   shreg, shreg_n, rx_byte;
  logic [PW-1:0]                ptr, ptr_n;
  logic                         sda_oe, sda_oe_n;
  logic                         rw, rw_n;
  logic                         act_n;
  logic                         i2c_we;
  logic [NUM_REGS-1:0][7:0]     regs;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    rw_n      = rw;
    act_n     = bus_active;
    i2c_we    = 1'b0;
    rx_byte   = {shreg[6:0], lvl[SDA]};
    if (stop_det) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
      act_n    = 1'b0;
    end else if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      act_n     = 1'b1;
    end else begin
      unique case (state)
        ST_ADDR, ST_PTR, ST_WDATA: if (rise[SCL]) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              ST_ADDR:
                if (rx_byte[7:1] == ADDR) begin
                  state_n = ST_ADDR_ACK;
                  rw_n    = rx_byte[0];
                end else begin
                  state_n = ST_IGNORE;
                end
              ST_PTR: begin
                ptr_n   = rx_byte[PW-1:0];
                state_n = ST_PTR_ACK;
              end
              default: begin
                i2c_we  = 1'b1;
                ptr_n   = ptr + PW'(1);
                state_n = ST_WDATA_ACK;
              end
            endcase
          end
        end
        // First SCL fall asserts ACK, second fall ends the ACK clock.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (fall[SCL]) begin
          if (!sda_oe) begin
            sda_oe_n = ~I2C_ACK;
          end else begin
            bit_cnt_n = '0;
            if (state == ST_ADDR_ACK && rw) begin
              shreg_n  = regs[ptr];
              sda_oe_n = ~regs[ptr][7];
              state_n  = ST_RDATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
            end
          end
        end
        ST_RDATA: if (fall[SCL]) begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            sda_oe_n = 1'b0;
            ptr_n    = ptr + PW'(1);
            state_n  = ST_RACK;
          end else begin
            shreg_n  = {shreg[6:0], 1'b0};
            sda_oe_n = ~shreg[6];
          end
        end
        // Entered on a fall, so the next fall always follows an ACK rise.
        ST_RACK:
          if (rise[SCL] && lvl[SDA] == I2C_NACK) begin
            state_n = ST_IGNORE;
          end else if (fall[SCL]) begin
            shreg_n   = regs[ptr];
            sda_oe_n  = ~regs[ptr][7];
            bit_cnt_n = '0;
            state_n   = ST_RDATA;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in_clk or posedge reset_reset)
    if (reset_reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      sda_oe     <= 1'b0;
      rw         <= 1'b0;
      bus_active <= 1'b0;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      ptr        <= ptr_n;
      sda_oe     <= sda_oe_n;
      rw         <= rw_n;
      bus_active <= act_n;
      wr_pulse   <= i2c_we;
      if (i2c_we) wr_addr <= ptr;
    end

  always_ff @(posedge clk_in_clk or posedge reset_reset)
    if (reset_reset) begin
      regs <= '0;
    end else begin
      if (loc_we) regs[loc_addr] <= loc_wdata;
      // I2C commit is applied last so it wins a same-register collision.
      if (i2c_we) regs[ptr] <= rx_byte;
    end

  assign regs_out       = regs;
  assign i2c.i2c_sda_oe = sda_oe;
  assign i2c.i2c_scl_oe = 1'b0;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bus-level bench: bit-banged I2C controller, randomized transactions checked
// against an array model of the register file and pointer.
module tb_i2c_target_regfile;
  import i2c_target_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int PW       = 4;
  localparam int Q        = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int COMMIT_LAT = 2 + I2C_FILT_LEN;
`else
  localparam int COMMIT_LAT = 2;
`endif

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic scl_drv = 1'b1, sda_drv = 1'b1;
  logic loc_we = 1'b0;
  logic [PW-1:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic [8*NUM_REGS-1:0] regs_out;
  logic wr_pulse, bus_active;
  logic [PW-1:0] wr_addr;

  i2c_target_regfile_if bus ();
  assign bus.i2c_scl_in = scl_drv & ~bus.i2c_scl_oe;
  assign bus.i2c_sda_in = sda_drv & ~bus.i2c_sda_oe;

  i2c_target_regfile #(.ADDR(7'h42), .NUM_REGS(NUM_REGS)) dut (
    .clk_in_clk (clk),
    .reset_reset(rst),
    .i2c        (bus.slave),
    .loc_we     (loc_we),
    .loc_addr   (loc_addr),
    .loc_wdata  (loc_wdata),
    .regs_out   (regs_out),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .bus_active (bus_active)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model
  logic [7:0] m_regs [NUM_REGS];
  int         m_ptr;
  int         exp_q[$];
  int         ci = 0;
  logic [7:0] txd [4];

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  // monitors
  int   got_q[$];
  int   oe_cnt = 0, oe_viol = 0;
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_pulse) got_q.push_back(int'(wr_addr) * 256 + int'(regs_out[int'(wr_addr)*8 +: 8]));
    if (bus.i2c_sda_oe) oe_cnt++;
    if (bus.i2c_sda_oe !== oe_prev && scl_drv && !rst) oe_viol++;
    oe_prev = bus.i2c_sda_oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic wait_q(); repeat (Q) @(negedge clk); endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_q(); scl_drv = 1'b1; wait_q();
    sda_drv = 1'b0; wait_q(); scl_drv = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_q(); scl_drv = 1'b1; wait_q(); sda_drv = 1'b1; wait_q();
  endtask

  task automatic wbit(input logic b, input bit coll, input bit glitch);
    sda_drv = b; wait_q(); scl_drv = 1'b1;
    if (coll) begin
      repeat (COMMIT_LAT) @(negedge clk);
      loc_we = 1'b1; @(negedge clk); loc_we = 1'b0;
      repeat (Q - COMMIT_LAT - 1) @(negedge clk);
    end else if (glitch) begin
      repeat (3) @(negedge clk); scl_drv = 1'b0;
      repeat (2) @(negedge clk); scl_drv = 1'b1;
      repeat (Q - 5) @(negedge clk);
    end else begin
      wait_q();
    end
    wait_q(); scl_drv = 1'b0; wait_q();
  endtask

  task automatic rbit(output logic b);
    sda_drv = 1'b1; wait_q(); scl_drv = 1'b1; wait_q();
    b = bus.i2c_sda_in; wait_q(); scl_drv = 1'b0; wait_q();
  endtask

  task automatic wbyte(input logic [7:0] v, output logic ack, input bit coll, input bit glitch);
    for (int i = 7; i >= 0; i--) wbit(v[i], coll && i == 0, glitch && i == 3);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin rbit(b); v[i] = b; end
    wbit(ack, 1'b0, 1'b0);
  endtask

  task automatic check_commits();
    chk("n_commit", 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = ci; i < exp_q.size(); i++)
      chk("commit", (i < got_q.size()) ? 128'(got_q[i]) : '1, 128'(exp_q[i]));
    ci = exp_q.size();
  endtask

  task automatic loc_write(input logic [PW-1:0] a, input logic [7:0] d);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    @(negedge clk); loc_we = 1'b0;
    m_regs[a] = d;
    chk("loc_wr", regs_out, m_flat());
  endtask

  task automatic do_write(input logic [7:0] p, input int n, input bit coll, input bit glitch);
    logic ack;
    i2c_start(); chk("active", bus_active, 1'b1);
    wbyte(8'h84, ack, 1'b0, 1'b0); chk("addr_ack", ack, I2C_ACK);
    wbyte(p, ack, 1'b0, 1'b0);     chk("ptr_ack", ack, I2C_ACK);
    m_ptr = p % NUM_REGS;
    for (int i = 0; i < n; i++) begin
      wbyte(txd[i], ack, coll && i == n - 1, glitch && i == 0);
      chk("data_ack", ack, I2C_ACK);
      m_regs[m_ptr] = txd[i];
      exp_q.push_back(m_ptr * 256 + int'(txd[i]));
      m_ptr = (m_ptr + 1) % NUM_REGS;
    end
    i2c_stop(); chk("idle", bus_active, 1'b0);
    check_commits();
    chk("wr_regs", regs_out, m_flat());
  endtask

  task automatic do_read(input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] v;
    i2c_start();
    wbyte(8'h84, ack, 1'b0, 1'b0); chk("addr_ack", ack, I2C_ACK);
    wbyte(p, ack, 1'b0, 1'b0);     chk("ptr_ack", ack, I2C_ACK);
    m_ptr = p % NUM_REGS;
    i2c_start();
    wbyte(8'h85, ack, 1'b0, 1'b0); chk("raddr_ack", ack, I2C_ACK);
    for (int i = 0; i < n; i++) begin
      rbyte(v, (i == n - 1) ? I2C_NACK : I2C_ACK);
      chk("rdata", v, m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % NUM_REGS;
    end
    chk("nack_release", bus.i2c_sda_oe, 1'b0);
    i2c_stop(); chk("idle", bus_active, 1'b0);
  endtask

  initial begin
    logic ack;
    int   oe0, p, n, kind;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sda_oe", bus.i2c_sda_oe, 1'b0);
    chk("rst_scl_oe", bus.i2c_scl_oe, 1'b0);
    chk("rst_wr_pulse", wr_pulse, 1'b0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_active", bus_active, 1'b0);
    chk("rst_regs", regs_out, '0);

    // write with pointer wrap
    txd[0] = 8'hA5; txd[1] = 8'h5A;
    do_write(8'h0F, 2, 1'b0, 1'b0);

    // read through repeated START
    loc_write(4'd3, 8'h3C);
    loc_write(4'd4, 8'hC3);
    do_read(8'h03, 2);

    // address mismatch: no drive, no commit
    oe0 = oe_cnt;
    i2c_start();
    wbyte(8'h86, ack, 1'b0, 1'b0); chk("mis_nack", ack, I2C_NACK);
    wbyte(8'h11, ack, 1'b0, 1'b0); chk("mis_nack2", ack, I2C_NACK);
    i2c_stop();
    chk("mis_oe", 128'(oe_cnt - oe0), '0);
    check_commits();
    chk("mis_regs", regs_out, m_flat());

    // STOP after 4 data bits, then a full write
    i2c_start();
    wbyte(8'h84, ack, 1'b0, 1'b0); chk("sm_addr_ack", ack, I2C_ACK);
    wbyte(8'h02, ack, 1'b0, 1'b0); chk("sm_ptr_ack", ack, I2C_ACK);
    for (int i = 0; i < 4; i++) wbit(1'($urandom), 1'b0, 1'b0);
    i2c_stop();
    chk("sm_idle", bus_active, 1'b0);
    check_commits();
    chk("sm_regs", regs_out, m_flat());
    txd[0] = 8'($urandom);
    do_write(8'h02, 1, 1'b0, 1'b0);

    // local write collides with I2C commit to reg5
    txd[0] = 8'($urandom);
    loc_addr = 4'd5; loc_wdata = ~txd[0];
    do_write(8'h05, 1, 1'b1, 1'b0);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    txd[0] = 8'($urandom); txd[1] = 8'($urandom);
    do_write(8'($urandom), 2, 1'b0, 1'b1);
`endif

    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      p    = $urandom_range(0, 255);
      n    = $urandom_range(1, 3);
      if (kind == 0) begin
        for (int i = 0; i < n; i++) txd[i] = 8'($urandom);
        do_write(8'(p), n, 1'b0, 1'b0);
      end else if (kind == 1) begin
        do_read(8'(p), n);
      end else begin
        loc_write(PW'($urandom_range(0, NUM_REGS - 1)), 8'($urandom));
      end
    end

    // reset while the target drives a 0 data bit
    loc_write(4'd6, 8'h12);
    i2c_start();
    wbyte(8'h84, ack, 1'b0, 1'b0);
    wbyte(8'h06, ack, 1'b0, 1'b0);
    i2c_start();
    wbyte(8'h85, ack, 1'b0, 1'b0); chk("rr_addr_ack", ack, I2C_ACK);
    sda_drv = 1'b1; wait_q(); scl_drv = 1'b1; wait_q();
    chk("rr_pre_oe", bus.i2c_sda_oe, 1'b1);
    #2 rst = 1'b1;
    #1 chk("rr_oe", bus.i2c_sda_oe, 1'b0);
    chk("rr_regs", regs_out, '0);
    chk("rr_active", bus_active, 1'b0);
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    repeat (3) @(negedge clk);
    scl_drv = 1'b0; wait_q();
    rst = 1'b0; wait_q();
    i2c_stop();
    txd[0] = 8'($urandom); txd[1] = 8'($urandom);
    do_write(8'($urandom), 2, 1'b0, 1'b0);

    chk("oe_while_scl_high", 128'(oe_viol), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
